// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, status codes, register ids
// and the exception-status helper used by the pipeline registers.
package y86_pkg;

  localparam int WORD_W = 64;
  localparam int STAT_W = 3;

  typedef enum logic [3:0] {
    HALT   = 4'h0,
    NOP    = 4'h1,
    RRMOVQ = 4'h2,
    IRMOVQ = 4'h3,
    RMMOVQ = 4'h4,
    MRMOVQ = 4'h5,
    OPQ    = 4'h6,
    JXX    = 4'h7,
    CALL   = 4'h8,
    RET    = 4'h9,
    PUSHQ  = 4'hA,
    POPQ   = 4'hB
  } icode_t;

  typedef enum logic [STAT_W-1:0] {
    AOK = 3'd1,
    HLT = 3'd2,
    ADR = 3'd3,
    INS = 3'd4
  } stat_t;

  localparam logic [3:0] REG_NONE = 4'hF;

  // Any of these statuses means the program has stopped architecturally.
  function automatic logic is_exc(input logic [STAT_W-1:0] stat);
    return (stat == HLT) || (stat == ADR) || (stat == INS);
  endfunction

endpackage

// File: rtl/exec_mem_pipe_reg_if.sv
// Execute-to-memory boundary bundle: execute results, ALU flags, stage
// control and the registered M-stage view plus condition codes.
interface exec_mem_pipe_reg_if #(
  parameter int WORD_W = y86_pkg::WORD_W,
  parameter int STAT_W = y86_pkg::STAT_W
);
  logic              m_stall;
  logic              m_bubble;
  logic [STAT_W-1:0] e_stat;
  logic [3:0]        e_icode;
  logic              e_cnd;
  logic [WORD_W-1:0] e_valE;
  logic [WORD_W-1:0] e_valA;
  logic [3:0]        e_dstE;
  logic [3:0]        e_dstM;
  logic              alu_zf;
  logic              alu_sf;
  logic              alu_of;
  logic [STAT_W-1:0] m_stat_in;
  logic [STAT_W-1:0] w_stat;
  logic [2:0]        cc_out;
  logic [STAT_W-1:0] M_stat;
  logic [3:0]        M_icode;
  logic              M_cnd;
  logic [WORD_W-1:0] M_valE;
  logic [WORD_W-1:0] M_valA;
  logic [3:0]        M_dstE;
  logic [3:0]        M_dstM;

  modport master (
    output m_stall, m_bubble, e_stat, e_icode, e_cnd, e_valE, e_valA,
           e_dstE, e_dstM, alu_zf, alu_sf, alu_of, m_stat_in, w_stat,
    input  cc_out, M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  m_stall, m_bubble, e_stat, e_icode, e_cnd, e_valE, e_valA,
           e_dstE, e_dstM, alu_zf, alu_sf, alu_of, m_stat_in, w_stat,
    output cc_out, M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
  );
endinterface

// File: rtl/cc_reg.sv
// Architectural condition-code register {OF,SF,ZF}; resets to ZF=1.
module cc_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_set_cc,
  input  logic [2:0] i_flags,
  output logic [2:0] o_cc
);
  logic [2:0] r_cc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cc <= 3'b001;
    end else if (i_set_cc) begin
      r_cc <= i_flags;
    end
  end

  assign o_cc = r_cc;
endmodule

// File: rtl/exec_mem_pipe_reg.sv
// E->M pipeline register of the PIPE core with stall/bubble control; also
// owns the condition codes that execute reads back.
module exec_mem_pipe_reg
  import y86_pkg::*;
(
  input logic              clk,
  input logic              reset,
  exec_mem_pipe_reg_if.slave bus
);
  logic [STAT_W-1:0] r_stat;
  logic [3:0]        r_icode;
  logic              r_cnd;
  logic [WORD_W-1:0] r_valE;
  logic [WORD_W-1:0] r_valA;
  logic [3:0]        r_dstE;
  logic [3:0]        r_dstM;
  logic              w_set_cc;

  always_ff @(posedge clk) begin
    if (reset || (bus.m_bubble && !bus.m_stall)) begin
      r_stat  <= AOK;
      r_icode <= NOP;
      r_cnd   <= 1'b0;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= REG_NONE;
      r_dstM  <= REG_NONE;
    end else if (!bus.m_stall) begin
      r_stat  <= bus.e_stat;
      r_icode <= bus.e_icode;
      r_cnd   <= bus.e_cnd;
      r_valE  <= bus.e_valE;
      r_valA  <= bus.e_valA;
      r_dstE  <= bus.e_dstE;
      r_dstM  <= bus.e_dstM;
    end
  end

  // A bubble only empties M; the OPq is still in execute, so it may set flags.
  assign w_set_cc = (bus.e_icode == OPQ) && !bus.m_stall && (bus.e_stat == AOK) &&
                    !is_exc(bus.m_stat_in) && !is_exc(bus.w_stat);

  cc_reg u_cc_reg (
    .clk      (clk),
    .reset    (reset),
    .i_set_cc (w_set_cc),
    .i_flags  ({bus.alu_of, bus.alu_sf, bus.alu_zf}),
    .o_cc     (bus.cc_out)
  );

  assign bus.M_stat  = r_stat;
  assign bus.M_icode = r_icode;
  assign bus.M_cnd   = r_cnd;
  assign bus.M_valE  = r_valE;
  assign bus.M_valA  = r_valA;
  assign bus.M_dstE  = r_dstE;
  assign bus.M_dstM  = r_dstM;
endmodule
